// File: rtl/serializer_mlane_if.sv
// Word-in / beat-out bus of the multi-lane serializer.
// The master side supplies words and downstream ready.
// The slave side (the serializer) returns beats, sideband and status.
interface serializer_mlane_if #(
  parameter int DATA_W = 16,
  parameter int LANES  = 1,
  parameter int MOD_W  = $clog2(DATA_W)
);
  logic [DATA_W-1:0] data_i;
  logic [MOD_W-1:0]  data_mod_i;
  logic              data_val_i;
  logic              data_rdy_o;
  logic [LANES-1:0]  ser_data_o;
  logic [LANES-1:0]  ser_keep_o;
  logic              ser_last_o;
  logic              ser_data_val_o;
  logic              ser_rdy_i;
  logic              drop_o;
  logic              busy_o;

  modport master (
    output data_i, data_mod_i, data_val_i, ser_rdy_i,
    input  data_rdy_o, ser_data_o, ser_keep_o, ser_last_o, ser_data_val_o, drop_o, busy_o
  );

  modport slave (
    input  data_i, data_mod_i, data_val_i, ser_rdy_i,
    output data_rdy_o, ser_data_o, ser_keep_o, ser_last_o, ser_data_val_o, drop_o, busy_o
  );
endinterface

// File: rtl/serializer_mlane.sv
// Multi-lane, length-programmable parallel-to-serial converter.
// The structure is an active word, whose current beat sits in the output registers
// and whose remaining bits sit in a shift register, plus a one-word holding buffer.
// A word arriving while the active slot is free bypasses the holding buffer.
// That bypass gives single-cycle latency.
// The holding buffer gives gap-free back-to-back streaming.
module serializer_mlane #(
  parameter int DATA_W    = 16,
  parameter int LANES     = 1,
  parameter int MOD_W     = $clog2(DATA_W),
  parameter int MIN_LEN   = 3,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  serializer_mlane_if.slave bus
);

  localparam int BEATS_MAX = DATA_W / LANES;
  localparam int CNT_W     = $clog2(BEATS_MAX) + 1;
  localparam int LEN_W     = MOD_W + 1;

  // Current output beat (registered outputs)
  logic [LANES-1:0]  ser_data_r, ser_data_n;
  logic [LANES-1:0]  ser_keep_r, ser_keep_n;
  logic              ser_last_r, ser_last_n;
  logic              ser_val_r, ser_val_n;
  // Remaining bits of the active word, and the beats still to follow the current beat
  logic [DATA_W-1:0] sh_r, sh_n;
  logic [CNT_W-1:0]  cnt_r, cnt_n;
  logic [LEN_W-1:0]  last_lanes_r, last_lanes_n;
  // Holding buffer
  logic [DATA_W-1:0] hold_data_r, hold_data_n;
  logic [LEN_W-1:0]  hold_len_r, hold_len_n;
  logic              hold_full_r, hold_full_n;
  // Status
  logic              data_rdy_r, data_rdy_n;
  logic              drop_r, drop_n;
  logic              busy_r, busy_n;

  logic [LEN_W-1:0]  len_s, src_len_s, first_lanes_s, last_lanes_s, adv_lanes_s;
  logic [DATA_W-1:0] src_data_s;
  logic [CNT_W-1:0]  beats_s;
  logic              accept_s, legal_s, done_s, adv_s, act_free_s, load_s;

  // Number of beats needed for a word of len bits.
  function automatic logic [CNT_W-1:0] beat_count(input logic [LEN_W-1:0] len);
    int n;
    n = (int'(len) + LANES - 1) / LANES;
    beat_count = CNT_W'(n);
  endfunction

  // Number of valid lanes on the final beat of a word of len bits.
  function automatic logic [LEN_W-1:0] tail_lanes(input logic [LEN_W-1:0] len);
    int n;
    n = (int'(len) + LANES - 1) / LANES;
    tail_lanes = LEN_W'(int'(len) - (n - 1) * LANES);
  endfunction

  // Keep mask with n valid lanes, anchored at the end that transmits first.
  function automatic logic [LANES-1:0] lane_mask(input logic [LEN_W-1:0] n);
    logic [LANES-1:0] m;
    logic             on;
    m = '0;
    for (int i = 0; i < LANES; i++) begin
      on = (LEN_W'(i) < n);
      if (MSB_FIRST) begin
        m[LANES-1-i] = on;
      end else begin
        m[i] = on;
      end
    end
    lane_mask = m;
  endfunction

  // Lanes of the next beat, taken from the transmit end of a word.
  function automatic logic [LANES-1:0] head(input logic [DATA_W-1:0] w);
    if (MSB_FIRST) begin
      head = w[DATA_W-1 -: LANES];
    end else begin
      head = w[LANES-1:0];
    end
  endfunction

  // Word with its next beat consumed.
  function automatic logic [DATA_W-1:0] tail(input logic [DATA_W-1:0] w);
    if (MSB_FIRST) begin
      tail = w << LANES;
    end else begin
      tail = w >> LANES;
    end
  endfunction

  // Next-state: accept/drop, bypass or promote into the active slot, beat advance
  always_comb begin
    len_s      = (bus.data_mod_i == {MOD_W{1'b0}}) ? LEN_W'(DATA_W) : {1'b0, bus.data_mod_i};
    accept_s   = bus.data_val_i & data_rdy_r;
    legal_s    = (len_s >= LEN_W'(MIN_LEN));
    done_s     = ser_val_r & bus.ser_rdy_i & ser_last_r;
    adv_s      = ser_val_r & bus.ser_rdy_i & ~ser_last_r;
    act_free_s = ~ser_val_r | done_s;
    load_s     = act_free_s & (hold_full_r | (accept_s & legal_s));

    if (hold_full_r) begin
      src_data_s = hold_data_r;
      src_len_s  = hold_len_r;
    end else begin
      src_data_s = bus.data_i;
      src_len_s  = len_s;
    end
    beats_s      = beat_count(src_len_s);
    last_lanes_s = tail_lanes(src_len_s);

    if (beats_s == CNT_W'(1)) begin
      first_lanes_s = last_lanes_s;
    end else begin
      first_lanes_s = LEN_W'(LANES);
    end
    if (cnt_r == CNT_W'(1)) begin
      adv_lanes_s = last_lanes_r;
    end else begin
      adv_lanes_s = LEN_W'(LANES);
    end

    ser_data_n   = ser_data_r;
    ser_keep_n   = ser_keep_r;
    ser_last_n   = ser_last_r;
    ser_val_n    = ser_val_r;
    sh_n         = sh_r;
    cnt_n        = cnt_r;
    last_lanes_n = last_lanes_r;
    hold_data_n  = hold_data_r;
    hold_len_n   = hold_len_r;

    if (load_s) begin
      ser_data_n   = head(src_data_s) & lane_mask(first_lanes_s);
      ser_keep_n   = lane_mask(first_lanes_s);
      ser_last_n   = (beats_s == CNT_W'(1));
      ser_val_n    = 1'b1;
      sh_n         = tail(src_data_s);
      cnt_n        = beats_s - CNT_W'(1);
      last_lanes_n = last_lanes_s;
    end else if (adv_s) begin
      ser_data_n   = head(sh_r) & lane_mask(adv_lanes_s);
      ser_keep_n   = lane_mask(adv_lanes_s);
      ser_last_n   = (cnt_r == CNT_W'(1));
      sh_n         = tail(sh_r);
      cnt_n        = cnt_r - CNT_W'(1);
    end else if (done_s) begin
      ser_data_n   = '0;
      ser_keep_n   = '0;
      ser_last_n   = 1'b0;
      ser_val_n    = 1'b0;
      sh_n         = '0;
      cnt_n        = '0;
    end else begin
      ser_val_n    = ser_val_r;
    end

    // Holding buffer: emptied on promote, filled only when the active slot stays busy.
    if (hold_full_r) begin
      hold_full_n = ~act_free_s;
    end else if (accept_s & legal_s & ~act_free_s) begin
      hold_full_n = 1'b1;
      hold_data_n = bus.data_i;
      hold_len_n  = len_s;
    end else begin
      hold_full_n = 1'b0;
    end

    data_rdy_n = ~hold_full_n;
    drop_n     = accept_s & ~legal_s;
    busy_n     = ser_val_n | hold_full_n;
  end

  // State and output registers; reset empties both slots and drops ready
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ser_data_r   <= '0;
      ser_keep_r   <= '0;
      ser_last_r   <= 1'b0;
      ser_val_r    <= 1'b0;
      sh_r         <= '0;
      cnt_r        <= '0;
      last_lanes_r <= '0;
      hold_data_r  <= '0;
      hold_len_r   <= '0;
      hold_full_r  <= 1'b0;
      data_rdy_r   <= 1'b0;
      drop_r       <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      ser_data_r   <= ser_data_n;
      ser_keep_r   <= ser_keep_n;
      ser_last_r   <= ser_last_n;
      ser_val_r    <= ser_val_n;
      sh_r         <= sh_n;
      cnt_r        <= cnt_n;
      last_lanes_r <= last_lanes_n;
      hold_data_r  <= hold_data_n;
      hold_len_r   <= hold_len_n;
      hold_full_r  <= hold_full_n;
      data_rdy_r   <= data_rdy_n;
      drop_r       <= drop_n;
      busy_r       <= busy_n;
    end
  end

  assign bus.data_rdy_o     = data_rdy_r;
  assign bus.ser_data_o     = ser_data_r;
  assign bus.ser_keep_o     = ser_keep_r;
  assign bus.ser_last_o     = ser_last_r;
  assign bus.ser_data_val_o = ser_val_r;
  assign bus.drop_o         = drop_r;
  assign bus.busy_o         = busy_r;

endmodule
